// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: serial scan of voices per note event, then a single issue cycle
// that commits allocation state and emits one-hot on/off pulses.
module midi_voice_allocator #(
  parameter int unsigned pChannel  = 4,
  parameter int unsigned pAgeWidth = 4
) (
  input  logic                             iCLK,
  input  logic                             inRST,
  input  logic [6:0]                       iNoteNumber,
  input  logic                             iNoteOn,
  input  logic                             iNoteOff,
  input  logic [pChannel-1:0]              iVoiceBusy,
  output logic                             oReady,
  output logic [pChannel-1:0]              oVoiceOn,
  output logic [pChannel-1:0]              oVoiceOff,
  output logic [6:0]                       oVoiceNote,
  output logic                             oSteal,
  output logic [$clog2(pChannel+1)-1:0]    oActiveCount,
  output logic                             oDropErr
);

  localparam int unsigned IdxW = (pChannel > 1) ? $clog2(pChannel) : 1;
  localparam int unsigned CntW = $clog2(pChannel + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StScan  = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 is_on_q, is_on_d;
  logic [6:0]           lnote_q, lnote_d;

  logic [pChannel-1:0]  alloc_q, alloc_d;
  logic [6:0]           note_q [pChannel];
  logic [6:0]           note_d [pChannel];
  logic [pAgeWidth-1:0] age_q [pChannel];
  logic [pAgeWidth-1:0] age_d [pChannel];

  logic                 match_vld_q, match_vld_d;
  logic [IdxW-1:0]      match_idx_q, match_idx_d;
  logic                 free_vld_q, free_vld_d;
  logic [IdxW-1:0]      free_idx_q, free_idx_d;
  logic                 rel_vld_q, rel_vld_d;
  logic [IdxW-1:0]      rel_idx_q, rel_idx_d;
  logic                 old_vld_q, old_vld_d;
  logic [IdxW-1:0]      old_idx_q, old_idx_d;
  logic [pAgeWidth-1:0] old_age_q, old_age_d;

  logic [pChannel-1:0]  von_q, von_d;
  logic [pChannel-1:0]  voff_q, voff_d;
  logic [6:0]           vnote_q, vnote_d;
  logic                 steal_q, steal_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 drop_q, drop_d;

  logic [IdxW-1:0]      chosen;
  logic                 do_steal;
  logic                 ev;

  assign ev = iNoteOn | iNoteOff;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    is_on_d     = is_on_q;
    lnote_d     = lnote_q;
    alloc_d     = alloc_q;
    note_d      = note_q;
    age_d       = age_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    rel_vld_d   = rel_vld_q;
    rel_idx_d   = rel_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    von_d       = '0;
    voff_d      = '0;
    vnote_d     = vnote_q;
    steal_d     = 1'b0;
    drop_d      = drop_q;
    chosen      = '0;
    do_steal    = 1'b0;

    case (state_q)
      StIdle: begin
        if (ev) begin
          lnote_d     = iNoteNumber;
          is_on_d     = iNoteOn;
          idx_d       = '0;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
          rel_vld_d   = 1'b0;
          old_vld_d   = 1'b0;
          old_age_d   = '0;
          state_d     = StScan;
          // Simultaneous on/off: the NoteOn wins, the NoteOff is lost.
          if (iNoteOn && iNoteOff) drop_d = 1'b1;
        end
      end
      StScan: begin
        if (ev) drop_d = 1'b1;
        if (alloc_q[idx_q] && (note_q[idx_q] == lnote_q) && !match_vld_q) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!alloc_q[idx_q] && !iVoiceBusy[idx_q] && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (!alloc_q[idx_q] && iVoiceBusy[idx_q] && !rel_vld_q) begin
          rel_vld_d = 1'b1;
          rel_idx_d = idx_q;
        end
        // Strict compare keeps the lowest index on age ties.
        if (alloc_q[idx_q] && (!old_vld_q || (age_q[idx_q] > old_age_q))) begin
          old_vld_d = 1'b1;
          old_idx_d = idx_q;
          old_age_d = age_q[idx_q];
        end
        if (idx_q == IdxW'(pChannel - 1)) begin
          state_d = StIssue;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StIssue: begin
        if (ev) drop_d = 1'b1;
        if (is_on_q) begin
          if (match_vld_q) begin
            chosen = match_idx_q;
          end else if (free_vld_q) begin
            chosen = free_idx_q;
          end else if (rel_vld_q) begin
            chosen = rel_idx_q;
          end else begin
            chosen   = old_idx_q;
            do_steal = 1'b1;
          end
          for (int i = 0; i < int'(pChannel); i++) begin
            if (IdxW'(i) == chosen) begin
              alloc_d[i] = 1'b1;
              note_d[i]  = lnote_q;
              age_d[i]   = '0;
            end else if (alloc_q[i] && (age_q[i] != {pAgeWidth{1'b1}})) begin
              age_d[i] = age_q[i] + 1'b1;
            end
          end
          von_d[chosen] = 1'b1;
          vnote_d       = lnote_q;
          steal_d       = do_steal;
        end else if (match_vld_q) begin
          alloc_d[match_idx_q] = 1'b0;
          voff_d[match_idx_q]  = 1'b1;
          vnote_d              = lnote_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cnt_d = '0;
    for (int i = 0; i < int'(pChannel); i++) begin
      cnt_d = cnt_d + CntW'(alloc_d[i]);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!inRST) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      is_on_q     <= 1'b0;
      lnote_q     <= '0;
      alloc_q     <= '0;
      for (int i = 0; i < int'(pChannel); i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      rel_vld_q   <= 1'b0;
      rel_idx_q   <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      von_q       <= '0;
      voff_q      <= '0;
      vnote_q     <= '0;
      steal_q     <= 1'b0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      is_on_q     <= is_on_d;
      lnote_q     <= lnote_d;
      alloc_q     <= alloc_d;
      note_q      <= note_d;
      age_q       <= age_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      rel_vld_q   <= rel_vld_d;
      rel_idx_q   <= rel_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      von_q       <= von_d;
      voff_q      <= voff_d;
      vnote_q     <= vnote_d;
      steal_q     <= steal_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign oReady       = (state_q == StIdle);
  assign oVoiceOn     = von_q;
  assign oVoiceOff    = voff_q;
  assign oVoiceNote   = vnote_q;
  assign oSteal       = steal_q;
  assign oActiveCount = cnt_q;
  assign oDropErr     = drop_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios plus random events against a voice-pool model.
module tb_midi_voice_allocator;
  localparam int NCH = 4;

  logic       iCLK = 1'b0;
  logic       inRST = 1'b0;
  logic [6:0] iNoteNumber = '0;
  logic       iNoteOn = 1'b0;
  logic       iNoteOff = 1'b0;
  logic [3:0] iVoiceBusy = '0;
  logic       oReady;
  logic [3:0] oVoiceOn;
  logic [3:0] oVoiceOff;
  logic [6:0] oVoiceNote;
  logic       oSteal;
  logic [2:0] oActiveCount;
  logic       oDropErr;

  midi_voice_allocator #(.pChannel(NCH), .pAgeWidth(4)) dut (
    .iCLK(iCLK), .inRST(inRST), .iNoteNumber(iNoteNumber), .iNoteOn(iNoteOn),
    .iNoteOff(iNoteOff), .iVoiceBusy(iVoiceBusy), .oReady(oReady), .oVoiceOn(oVoiceOn),
    .oVoiceOff(oVoiceOff), .oVoiceNote(oVoiceNote), .oSteal(oSteal),
    .oActiveCount(oActiveCount), .oDropErr(oDropErr)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  // Voice pool model
  bit         m_alloc [NCH];
  int         m_note  [NCH];
  int         m_age   [NCH];
  int         m_last_note;
  bit         m_drop;
  int         m_count;
  logic [3:0] e_on, e_off;
  logic       e_steal;

  // Values seen at the pulse cycle of the last event
  logic [3:0] obs_on, obs_off;
  logic       obs_steal;
  logic [2:0] obs_cnt;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_alloc[i] = 0; m_note[i] = 0; m_age[i] = 0;
    end
    m_last_note = 0; m_drop = 0; m_count = 0;
  endfunction

  function automatic void model_event(bit on, bit off, int n, logic [3:0] busy);
    int ch;
    e_on = '0; e_off = '0; e_steal = 1'b0;
    if (on && off) m_drop = 1;
    if (on) begin
      ch = -1;
      for (int i = 0; i < NCH; i++) if (ch < 0 && m_alloc[i] && m_note[i] == n) ch = i;
      for (int i = 0; i < NCH; i++) if (ch < 0 && !m_alloc[i] && !busy[i]) ch = i;
      for (int i = 0; i < NCH; i++) if (ch < 0 && !m_alloc[i] && busy[i]) ch = i;
      if (ch < 0) begin
        e_steal = 1'b1;
        for (int i = 0; i < NCH; i++)
          if (m_alloc[i] && (ch < 0 || m_age[i] > m_age[ch])) ch = i;
      end
      for (int i = 0; i < NCH; i++) begin
        if (i == ch) begin
          m_alloc[i] = 1; m_note[i] = n; m_age[i] = 0;
        end else if (m_alloc[i]) begin
          m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
        end
      end
      e_on[ch] = 1'b1;
      m_last_note = n;
    end else if (off) begin
      ch = -1;
      for (int i = 0; i < NCH; i++) if (ch < 0 && m_alloc[i] && m_note[i] == n) ch = i;
      if (ch >= 0) begin
        m_alloc[ch] = 0; e_off[ch] = 1'b1; m_last_note = n;
      end
    end
    m_count = 0;
    for (int i = 0; i < NCH; i++) m_count += int'(m_alloc[i]);
  endfunction

  task automatic pulse_reset();
    @(negedge iCLK);
    inRST = 1'b0; iNoteOn = 1'b0; iNoteOff = 1'b0; iVoiceBusy = '0;
    repeat (2) @(posedge iCLK);
    #1 inRST = 1'b1;
    model_reset();
  endtask

  // Drive one event, check nothing fires early, then check the pulse cycle against the model.
  task automatic do_event(input bit on, input bit off, input int n, input logic [3:0] busy);
    @(negedge iCLK);
    iNoteOn = on; iNoteOff = off; iNoteNumber = 7'(n); iVoiceBusy = busy;
    @(posedge iCLK);
    #1 iNoteOn = 1'b0; iNoteOff = 1'b0;
    model_event(on, off, n, busy);
    repeat (4) @(posedge iCLK);
    #1;
    checks++;
    if (oVoiceOn !== 4'b0 || oVoiceOff !== 4'b0 || oReady !== 1'b0) begin
      errors++;
      $display("FAIL early_pulse got on=%b off=%b ready=%b required on=0000 off=0000 ready=0",
               oVoiceOn, oVoiceOff, oReady);
    end
    @(posedge iCLK);
    #1;
    obs_on = oVoiceOn; obs_off = oVoiceOff; obs_steal = oSteal; obs_cnt = oActiveCount;
    checks++;
    if (oVoiceOn !== e_on || oVoiceOff !== e_off || oSteal !== e_steal) begin
      errors++;
      $display("FAIL pulses note=%0d got on=%b off=%b steal=%b required on=%b off=%b steal=%b",
               n, oVoiceOn, oVoiceOff, oSteal, e_on, e_off, e_steal);
    end
    checks++;
    if (oVoiceNote !== 7'(m_last_note) || oActiveCount !== 3'(m_count)) begin
      errors++;
      $display("FAIL note_count got note=%0d count=%0d required note=%0d count=%0d",
               oVoiceNote, oActiveCount, m_last_note, m_count);
    end
    checks++;
    if (oDropErr !== m_drop || oReady !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready got drop=%b ready=%b required drop=%b ready=1",
               oDropErr, oReady, m_drop);
    end
    @(posedge iCLK);
    #1;
    checks++;
    if (oVoiceOn !== 4'b0 || oVoiceOff !== 4'b0 || oSteal !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width got on=%b off=%b steal=%b required 0000 0000 0",
               oVoiceOn, oVoiceOff, oSteal);
    end
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({oReady, oVoiceOn, oVoiceOff, oVoiceNote, oSteal, oActiveCount, oDropErr} !==
        {1'b1, 4'b0, 4'b0, 7'd0, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got ready=%b on=%b off=%b note=%0d steal=%b cnt=%0d drop=%b required 1 0000 0000 0 0 0 0",
               oReady, oVoiceOn, oVoiceOff, oVoiceNote, oSteal, oActiveCount, oDropErr);
    end
  endtask

  task automatic test_first_note();
    pulse_reset();
    do_event(1, 0, 60, 4'b0);
    checks++;
    if (obs_on !== 4'b0001 || obs_steal !== 1'b0 || obs_cnt !== 3'd1) begin
      errors++;
      $display("FAIL first_note got on=%b steal=%b cnt=%0d required 0001 0 1", obs_on, obs_steal, obs_cnt);
    end
  endtask

  task automatic test_note_off();
    pulse_reset();
    do_event(1, 0, 60, 4'b0);
    do_event(1, 0, 62, 4'b0);
    do_event(1, 0, 64, 4'b0);
    do_event(1, 0, 67, 4'b0);
    do_event(0, 1, 62, 4'b0);
    checks++;
    if (obs_off !== 4'b0010 || obs_on !== 4'b0) begin
      errors++;
      $display("FAIL note_off got off=%b on=%b required off=0010 on=0000", obs_off, obs_on);
    end
    do_event(1, 0, 69, 4'b0);
    checks++;
    if (obs_on !== 4'b0010) begin
      errors++;
      $display("FAIL refill got on=%b required 0010", obs_on);
    end
  endtask

  task automatic test_steal();
    pulse_reset();
    do_event(1, 0, 60, 4'b0);
    do_event(1, 0, 62, 4'b0);
    do_event(1, 0, 64, 4'b0);
    do_event(1, 0, 67, 4'b0);
    do_event(1, 0, 72, 4'b0);
    checks++;
    if (obs_on !== 4'b0001 || obs_steal !== 1'b1 || obs_cnt !== 3'd4 || obs_off !== 4'b0) begin
      errors++;
      $display("FAIL steal got on=%b steal=%b cnt=%0d off=%b required 0001 1 4 0000",
               obs_on, obs_steal, obs_cnt, obs_off);
    end
    do_event(0, 1, 60, 4'b0);
    checks++;
    if (obs_off !== 4'b0 || obs_cnt !== 3'd4) begin
      errors++;
      $display("FAIL stale_off got off=%b cnt=%0d required 0000 4", obs_off, obs_cnt);
    end
  endtask

  task automatic test_retrigger();
    pulse_reset();
    do_event(1, 0, 60, 4'b0);
    do_event(1, 0, 60, 4'b0);
    checks++;
    if (obs_on !== 4'b0001 || obs_cnt !== 3'd1 || obs_steal !== 1'b0) begin
      errors++;
      $display("FAIL retrigger got on=%b cnt=%0d steal=%b required 0001 1 0", obs_on, obs_cnt, obs_steal);
    end
  endtask

  task automatic test_releasing();
    pulse_reset();
    do_event(1, 0, 60, 4'b0);
    do_event(0, 1, 60, 4'b0001);
    do_event(1, 0, 62, 4'b0001);
    checks++;
    if (obs_on !== 4'b0010) begin
      errors++;
      $display("FAIL free_over_release got on=%b required 0010", obs_on);
    end
    pulse_reset();
    do_event(1, 0, 64, 4'b1111);
    checks++;
    if (obs_on !== 4'b0001 || obs_steal !== 1'b0) begin
      errors++;
      $display("FAIL all_busy got on=%b steal=%b required 0001 0", obs_on, obs_steal);
    end
    do_event(1, 0, 65, 4'b1111);
  endtask

  task automatic test_drop();
    pulse_reset();
    @(negedge iCLK);
    iNoteOn = 1'b1; iNoteNumber = 7'd40;
    @(posedge iCLK);
    #1 iNoteOn = 1'b0;
    model_event(1, 0, 40, 4'b0);
    @(posedge iCLK);
    @(negedge iCLK);
    iNoteOn = 1'b1; iNoteNumber = 7'd41;
    @(posedge iCLK);
    #1 iNoteOn = 1'b0;
    m_drop = 1;
    checks++;
    if (oDropErr !== 1'b1) begin
      errors++;
      $display("FAIL drop_flag got %b required 1", oDropErr);
    end
    repeat (3) @(posedge iCLK);
    #1;
    checks++;
    if (oVoiceOn !== 4'b0001 || oVoiceNote !== 7'd40 || oActiveCount !== 3'd1) begin
      errors++;
      $display("FAIL drop_first got on=%b note=%0d cnt=%0d required 0001 40 1",
               oVoiceOn, oVoiceNote, oActiveCount);
    end
    do_event(1, 1, 50, 4'b0);
  endtask

  task automatic test_reset_mid_scan();
    pulse_reset();
    do_event(1, 0, 33, 4'b0);
    @(negedge iCLK);
    iNoteOn = 1'b1; iNoteNumber = 7'd50;
    @(posedge iCLK);
    #1 iNoteOn = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    inRST = 1'b0;
    @(posedge iCLK);
    #1 inRST = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({oVoiceOn, oVoiceOff, oVoiceNote, oSteal, oActiveCount, oDropErr, oReady} !==
          {4'b0, 4'b0, 7'd0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL mid_scan_reset cyc=%0d got on=%b off=%b note=%0d steal=%b cnt=%0d drop=%b ready=%b required all 0 ready=1",
                 c, oVoiceOn, oVoiceOff, oVoiceNote, oSteal, oActiveCount, oDropErr, oReady);
      end
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic test_random();
    int r;
    pulse_reset();
    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 9));
      do_event(r < 6 || r == 9, r >= 6, 60 + int'($urandom_range(0, 5)), 4'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_note_off();
    test_steal();
    test_retrigger();
    test_releasing();
    test_drop();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
